// File: rtl/score_collector.sv
// -----------------------------------------------------------------------------
// score_collector
//
// Collects the ten class scores of one frame from a valid/ready stream. It
// tracks the running argmax while collecting, then presents the whole frame
// with its maximum to the softmax stage until the consumer takes it.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     in_score / in_last valid this cycle
//   in_ready     collector accepts a score this cycle (COLLECT and not in reset)
//   in_score     signed class score, classes arrive in order 0..9
//   in_last      marks the 10th score of a frame
//   scores_out   buffered scores, entry i is class i (meaningful while out_valid)
//   out_valid    complete frame presented
//   out_ready    downstream consumes the presented frame
//   max_index    argmax class of the presented frame (ties -> lowest index)
//   max_value    maximum score of the presented frame
//   frame_err    one-cycle pulse after a badly framed score sequence
//   frame_count  number of frames handed off, wraps at 16 bits
// -----------------------------------------------------------------------------
module score_collector #(
  parameter  int LAYER2_BITS = 61,
  localparam int W           = LAYER2_BITS + 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_score,
  input  logic                 in_last,
  output logic [9:0][W-1:0]    scores_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           max_index,
  output logic signed [W-1:0]  max_value,
  output logic                 frame_err,
  output logic [15:0]          frame_count
);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'd9;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [9:0][W-1:0]     scores_q, scores_d;
  logic [3:0]            max_idx_q, max_idx_d;
  logic signed [W-1:0]   max_val_q, max_val_d;
  logic                  frame_err_q, frame_err_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic accept;

  // Gating with rst keeps the producer stalled during the reset cycle itself.
  assign in_ready = (state_q == COLLECT) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    scores_d      = scores_q;
    max_idx_d     = max_idx_q;
    max_val_d     = max_val_q;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          scores_d[cnt_q] = in_score;
          // First score seeds the running max; later ones replace it only when
          // strictly larger, so ties keep the lower class index.
          if (cnt_q == 4'd0 || in_score > max_val_q) begin
            max_val_d = in_score;
            max_idx_d = cnt_q;
          end

          if (in_last && cnt_q == LAST_CNT) begin
            state_d = PRESENT;
            cnt_d   = 4'd0;
          end else if (in_last || cnt_q == LAST_CNT) begin
            // in_last and the 10th slot disagree: drop the frame and resync.
            frame_err_d = 1'b1;
            cnt_d       = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      PRESENT: begin
        if (out_ready) begin
          state_d       = COLLECT;
          cnt_d         = 4'd0;
          frame_count_d = frame_count_q + 16'd1;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= COLLECT;
      cnt_q         <= 4'd0;
      // NOTE: the score buffer is reset too, because consumers expect zeroed
      // entries after reset; it is small enough to live in flops.
      scores_q      <= '0;
      max_idx_q     <= 4'd0;
      max_val_q     <= '0;
      frame_err_q   <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scores_q      <= scores_d;
      max_idx_q     <= max_idx_d;
      max_val_q     <= max_val_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign scores_out  = scores_q;
  assign out_valid   = (state_q == PRESENT);
  assign max_index   = max_idx_q;
  assign max_value   = max_val_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_score_collector.sv
// -----------------------------------------------------------------------------
// tb_score_collector
//
// Self-checking bench for score_collector. A frame-level reference model
// (queue of accepted scores, argmax computed over the complete frame) is
// stepped alongside the DUT and compared every cycle. Table-driven frames and
// hand-written sequences cover the named scenarios; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_score_collector;

  localparam int LAYER2_BITS = 61;
  localparam int W           = LAYER2_BITS + 25;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_score;
  logic                in_last;
  logic [9:0][W-1:0]   scores_out;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          max_index;
  logic signed [W-1:0] max_value;
  logic                frame_err;
  logic [15:0]         frame_count;

  score_collector #(.LAYER2_BITS(LAYER2_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_score    (in_score),
    .in_last     (in_last),
    .scores_out  (scores_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .max_index   (max_index),
    .max_value   (max_value),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frame level. Scores are queued as they are accepted; the
  // frame's argmax is derived only once the whole frame is known.
  // ---------------------------------------------------------------------------
  logic [W-1:0]       m_buf[$];
  bit                 m_present;
  logic [9:0][W-1:0]  m_scores;
  logic [3:0]         m_idx;
  logic [W-1:0]       m_val;
  logic [15:0]        m_count;
  bit                 m_err;
  bit                 last_acc;
  bit                 checking = 0;

  task automatic model_edge(input bit v, input logic [W-1:0] sc, input bit lst,
                            input bit ordy, input bit r);
    last_acc = 0;
    if (r) begin
      m_buf.delete();
      m_present = 0;
      m_scores  = '0;
      m_idx     = '0;
      m_val     = '0;
      m_count   = '0;
      m_err     = 0;
      return;
    end
    m_err = 0;
    if (!m_present) begin
      if (v) begin
        last_acc = 1;
        m_buf.push_back(sc);
        if (lst && m_buf.size() == 10) begin
          for (int k = 0; k < 10; k++) begin
            m_scores[k] = m_buf[k];
            if (k == 0 || $signed(m_buf[k]) > $signed(m_val)) begin
              m_val = m_buf[k];
              m_idx = 4'(k);
            end
          end
          m_present = 1;
          m_buf.delete();
        end else if (lst || m_buf.size() == 10) begin
          m_err = 1;
          m_buf.delete();
        end
      end
    end else if (ordy) begin
      m_present = 0;
      m_count   = m_count + 16'd1;
    end
  endtask

  // Compare DUT against the model; called at the negedge, away from clk rise.
  task automatic compare();
    if (!checking) return;
    check("in_ready", in_ready, !m_present && !rst);
    check("out_valid", out_valid, m_present);
    check("frame_err", frame_err, m_err);
    check("frame_count", frame_count, m_count);
    if (m_present) begin
      check("max_index", max_index, m_idx);
      check("max_value", max_value, m_val);
      for (int k = 0; k < 10; k++) check($sformatf("scores_out[%0d]", k), scores_out[k], m_scores[k]);
    end
  endtask

  // One clock cycle: check, drive, advance to the next negedge.
  task automatic step(input bit v, input logic [W-1:0] sc, input bit lst,
                      input bit ordy, input bit r);
    compare();
    in_valid  = v;
    in_score  = sc;
    in_last   = lst;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    model_edge(v, sc, lst, ordy, r);
    @(negedge clk);
  endtask

  // Stream n scores; in_last on index last_at (-1 for none); gap inserts an
  // idle cycle between consecutive valid cycles.
  task automatic drive_frame(input logic [9:0][W-1:0] s, input int n, input int last_at,
                             input bit gap, input bit ordy);
    int i = 0;
    int budget = 0;
    bit idle_turn = 0;
    while (i < n && budget < 200) begin
      if (gap && idle_turn) begin
        step(0, '0, 0, ordy, 0);
      end else begin
        step(1, s[i], (i == last_at), ordy, 0);
        if (last_acc) i++;
      end
      idle_turn = gap ? !idle_turn : 1'b0;
      budget++;
    end
    check("drive_budget", 32'(i), 32'(n));
  endtask

  typedef struct {
    logic [9:0][W-1:0] s;
    bit                gap;
    logic [3:0]        exp_idx;
    logic [W-1:0]      exp_val;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int basic[10];
    logic [W-1:0] neg_max;
    logic [W-1:0] pos_max;
    logic [9:0][W-1:0] s;
    logic [W-1:0] held[10];
    logic [15:0] base;

    basic   = '{5, -3, 12, 7, 0, 12, -1, 4, 9, 2};
    neg_max = {1'b1, {(W-1){1'b0}}};
    pos_max = {1'b0, {(W-1){1'b1}}};

    // Table: frame scores and the expected presented result.
    for (int k = 0; k < 10; k++) begin
      vecs[0].s[k] = basic[k];
      vecs[1].s[k] = basic[k];
      vecs[2].s[k] = -8;
      vecs[3].s[k] = k;
      vecs[4].s[k] = '0;
    end
    vecs[4].s[0] = neg_max;
    vecs[4].s[7] = pos_max;
    vecs[0].gap = 0; vecs[0].exp_idx = 4'd2; vecs[0].exp_val = 12;
    vecs[1].gap = 1; vecs[1].exp_idx = 4'd2; vecs[1].exp_val = 12;
    vecs[2].gap = 0; vecs[2].exp_idx = 4'd0; vecs[2].exp_val = -8;
    vecs[3].gap = 0; vecs[3].exp_idx = 4'd9; vecs[3].exp_val = 9;
    vecs[4].gap = 0; vecs[4].exp_idx = 4'd7; vecs[4].exp_val = pos_max;

    // Reset: first edge seeds DUT and model together.
    in_valid = 0; in_score = '0; in_last = 0; out_ready = 0; rst = 1;
    @(posedge clk);
    model_edge(0, '0, 0, 0, 1);
    @(negedge clk);
    checking = 1;
    step(0, '0, 0, 0, 1);
    // rst still high here
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_max_index", max_index, 0);
    check("rst_max_value", max_value, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_scores_out7", scores_out[7], 0);
    step(0, '0, 0, 0, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      base = frame_count;
      drive_frame(vecs[i].s, 10, 9, vecs[i].gap, 1);
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_in_ready", i), in_ready, 0);
      check($sformatf("vec%0d_max_index", i), max_index, vecs[i].exp_idx);
      check($sformatf("vec%0d_max_value", i), max_value, vecs[i].exp_val);
      for (int k = 0; k < 10; k++)
        check($sformatf("vec%0d_score%0d", i, k), scores_out[k], vecs[i].s[k]);
      step(0, '0, 0, 1, 0);
      check($sformatf("vec%0d_out_valid_1cyc", i), out_valid, 0);
      check($sformatf("vec%0d_frame_count", i), frame_count, 16'(i + 1));
    end

    // Backpressure: presented frame held while out_ready is low.
    base = frame_count;
    drive_frame(vecs[2].s, 10, 9, 0, 0);
    for (int k = 0; k < 10; k++) held[k] = scores_out[k];
    for (int c = 0; c < 20; c++) step(0, '0, 0, 0, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    check("bp_max_index", max_index, 0);
    for (int k = 0; k < 10; k++) check($sformatf("bp_stable%0d", k), scores_out[k], held[k]);
    step(0, '0, 0, 1, 0);
    check("bp_released", out_valid, 0);
    check("bp_frame_count", frame_count, base + 16'd1);

    // Framing error: in_last on the 4th score.
    base = frame_count;
    drive_frame(vecs[3].s, 4, 3, 0, 1);
    check("ferr_pulse", frame_err, 1);
    check("ferr_no_valid", out_valid, 0);
    step(0, '0, 0, 1, 0);
    check("ferr_one_cycle", frame_err, 0);
    drive_frame(vecs[3].s, 10, 9, 0, 1);
    check("ferr_next_idx", max_index, 9);
    check("ferr_next_val", max_value, 9);
    step(0, '0, 0, 1, 0);
    check("ferr_count", frame_count, base + 16'd1);

    // Framing error: 10th score without in_last.
    drive_frame(vecs[0].s, 10, -1, 0, 1);
    check("ferr_nolast_pulse", frame_err, 1);
    check("ferr_nolast_valid", out_valid, 0);
    step(0, '0, 0, 1, 0);

    // Reset mid-frame after the 6th score.
    drive_frame(vecs[0].s, 6, -1, 0, 1);
    step(0, '0, 0, 1, 1);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_frame_count", frame_count, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_max_value", max_value, 0);
    check("mid_rst_score2", scores_out[2], 0);
    step(0, '0, 0, 1, 0);
    drive_frame(vecs[0].s, 10, 9, 0, 1);
    check("mid_rst_idx", max_index, 2);
    check("mid_rst_val", max_value, 12);
    step(0, '0, 0, 1, 0);
    check("mid_rst_count1", frame_count, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit v, lst, ordy, r;
      logic [W-1:0] sc;
      r    = ($urandom_range(0, 199) == 0);
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 1) == 1);
      if (m_buf.size() == 9) lst = ($urandom_range(0, 9) != 0);
      else                   lst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) == 0) sc = W'({$urandom, $urandom, $urandom});
      else                           sc = W'(int'($urandom_range(0, 8)) - 4);
      step(v, sc, lst, ordy, r);
    end
    step(0, '0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
